// File: rtl/mem_arbiter.sv
// Two-requester arbiter serialising 16-bit big-endian words onto a byte-wide memory (HI byte, then LO byte).
// Latency: done pulses in the 3rd cycle after the sampling edge; an IDLE cycle follows, so throughput is 4 cycles per word.
// Backpressure: requesters wait with req high until granted. MEM_ARBITER_ROUND_ROBIN_EN selects round-robin ties (default: fixed priority to 0).
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [WORD_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                pick;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // last_q remembers the most recent winner; reset to 1 so the first tie goes to requester 0
    logic last_q, last_d;

    assign pick   = req0 ? (req1 ? ~last_q : 1'b0) : 1'b1;
    assign last_d = (state_q == IDLE && (req0 || req1)) ? pick : last_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick = ~req0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = HI;
                    sel_d   = pick;
                    we_d    = pick ? we1    : we0;
                    addr_d  = pick ? addr1  : addr0;
                    wdata_d = pick ? wdata1 : wdata0;
                end
            end
            HI: begin
                state_d   = LO;
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_wdata = wdata_q[WORD_W-1 -: 8];
                if (!we_q) rdata_d[WORD_W-1 -: 8] = mem_rdata;
            end
            LO: begin
                state_d   = DONE;
                // ADDR_W-bit add wraps the last byte of memory back to address 0
                mem_addr  = addr_q + ADDR_W'(1);
                mem_we    = we_q;
                mem_wdata = wdata_q[7:0];
                if (!we_q) rdata_d[7:0] = mem_rdata;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign gnt0  = busy & ~sel_q;
    assign gnt1  = busy &  sel_q;
    assign done0 = (state_q == DONE) & ~sel_q;
    assign done1 = (state_q == DONE) &  sel_q;
    assign rdata = rdata_q;

endmodule
